gpio_pad_ctrl: RTL and testbench

Parametrised multi-channel GPIO controller that sits between the register/peripheral logic and a row of tri-state pull-capable pad cells. Per channel it registers pad drive, output-enable and pull controls, and synchronises the pad input. It also debounces the input (optional) and raises sticky, maskable edge interrupts. It is the next generation of the single-bit pad models: one instance drives `CH_NUM` pads and adds sequential input conditioning.

---
 rtl/gpio_pad_ctrl.sv | 135 +++++++++++++
 tb/tb_gpio_pad_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pad_ctrl.sv
// Multi-channel GPIO pad controller: registered pad controls, input synchroniser,
// optional debounce (define GPIO_PAD_CTRL_DEBOUNCE_EN) and sticky maskable edge interrupts.
module gpio_pad_ctrl #(
    parameter int CH_NUM       = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int DB_CNT_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [CH_NUM-1:0]       dir_i,
    input  logic [CH_NUM-1:0]       dout_i,
    input  logic [CH_NUM-1:0]       pull_en_i,
    input  logic [DB_CNT_WIDTH-1:0] db_thresh_i,
    input  logic [CH_NUM-1:0]       rise_en_i,
    input  logic [CH_NUM-1:0]       fall_en_i,
    input  logic [CH_NUM-1:0]       irq_clr_i,
    output logic [CH_NUM-1:0]       din_o,
    output logic [CH_NUM-1:0]       irq_stat_o,
    output logic                    irq_o,
    input  logic [CH_NUM-1:0]       pad_c_i,
    output logic [CH_NUM-1:0]       pad_i_o,
    output logic [CH_NUM-1:0]       pad_oen_o,
    output logic [CH_NUM-1:0]       pad_ren_o
);

    logic [CH_NUM-1:0] pad_i_q;
    logic [CH_NUM-1:0] pad_oen_q;
    logic [CH_NUM-1:0] pad_ren_q;
    logic [CH_NUM-1:0] sync_q [SYNC_STAGES];
    logic [CH_NUM-1:0] sync_s;
    logic [CH_NUM-1:0] din_s;
    logic [CH_NUM-1:0] prev_q;
    logic [CH_NUM-1:0] irq_stat_q;
    logic [CH_NUM-1:0] irq_stat_d;
    logic [CH_NUM-1:0] rise_s;
    logic [CH_NUM-1:0] fall_s;

    // Pad control registers; reset leaves every pad tri-stated with pulls off.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pad_i_q   <= '0;
            pad_oen_q <= '1;
            pad_ren_q <= '1;
        end else begin
            pad_i_q   <= dout_i;
            pad_oen_q <= ~dir_i;
            pad_ren_q <= ~pull_en_i;
        end
    end

    // Synchroniser chain for the asynchronous pad receiver outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= pad_c_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
    logic [DB_CNT_WIDTH-1:0] cnt_q [CH_NUM];
    logic [DB_CNT_WIDTH-1:0] cnt_d [CH_NUM];
    logic [CH_NUM-1:0]       stb_q;
    logic [CH_NUM-1:0]       stb_d;

    // Debounce next state; >= lets a lowered threshold take effect at once.
    always_comb begin
        stb_d = stb_q;
        for (int n = 0; n < CH_NUM; n++) begin
            cnt_d[n] = cnt_q[n];
            if (sync_s[n] == stb_q[n]) begin
                cnt_d[n] = '0;
            end else if (cnt_q[n] >= db_thresh_i) begin
                stb_d[n] = sync_s[n];
                cnt_d[n] = '0;
            end else begin
                cnt_d[n] = cnt_q[n] + DB_CNT_WIDTH'(1);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stb_q <= '0;
            for (int n = 0; n < CH_NUM; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            stb_q <= stb_d;
            for (int n = 0; n < CH_NUM; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    assign din_s = stb_q;
`else
    logic unused_thresh_s;

    assign unused_thresh_s = ^db_thresh_i;
    assign din_s           = sync_s;
`endif

    // A same-cycle event overrides a clear so no edge is ever lost.
    assign rise_s     = din_s & ~prev_q;
    assign fall_s     = ~din_s & prev_q;
    assign irq_stat_d = (irq_stat_q & ~irq_clr_i) | (rise_s & rise_en_i) | (fall_s & fall_en_i);

    // Edge history and sticky status registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q     <= '0;
            irq_stat_q <= '0;
        end else begin
            prev_q     <= din_s;
            irq_stat_q <= irq_stat_d;
        end
    end

    assign din_o      = din_s;
    assign irq_stat_o = irq_stat_q;
    assign irq_o      = |irq_stat_q;
    assign pad_i_o    = pad_i_q;
    assign pad_oen_o  = pad_oen_q;
    assign pad_ren_o  = pad_ren_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed scoreboard bench for gpio_pad_ctrl (CH_NUM=8, SYNC_STAGES=2, threshold 3);
// latencies follow GPIO_PAD_CTRL_DEBOUNCE_EN when it is defined.
module tb_gpio_pad_ctrl;

    localparam int S = 2;
`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
    localparam int LAT = S + 3;
`else
    localparam int LAT = S - 1;
`endif

    localparam int SIG_DIN  = 0;
    localparam int SIG_STAT = 1;
    localparam int SIG_IRQ  = 2;
    localparam int SIG_PADI = 3;
    localparam int SIG_OEN  = 4;
    localparam int SIG_REN  = 5;

    typedef struct {
        int         due;
        int         sig;
        logic [7:0] mask;
        logic [7:0] exp;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dir, dout, pull_en, db_thresh, rise_en, fall_en, irq_clr, pad_c;
    logic [7:0] din, irq_stat, pad_i, pad_oen, pad_ren;
    logic       irq;

    int   edge_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;
    exp_t sb[$];

    gpio_pad_ctrl #(.CH_NUM(8), .SYNC_STAGES(S), .DB_CNT_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .dir_i(dir), .dout_i(dout), .pull_en_i(pull_en),
        .db_thresh_i(db_thresh), .rise_en_i(rise_en), .fall_en_i(fall_en),
        .irq_clr_i(irq_clr), .din_o(din), .irq_stat_o(irq_stat), .irq_o(irq),
        .pad_c_i(pad_c), .pad_i_o(pad_i), .pad_oen_o(pad_oen), .pad_ren_o(pad_ren)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [7:0] sig_val(input int sig);
        case (sig)
            SIG_DIN:  return din;
            SIG_STAT: return irq_stat;
            SIG_IRQ:  return {7'b0000000, irq};
            SIG_PADI: return pad_i;
            SIG_OEN:  return pad_oen;
            SIG_REN:  return pad_ren;
            default:  return 8'hxx;
        endcase
    endfunction

    // off = 0 means "after the edge that samples what is driven now"
    task automatic sb_push(input int off, input int sig, input logic [7:0] mask,
                           input logic [7:0] val, input string tag);
        exp_t e;
        e.due  = edge_cnt + 1 + off;
        e.sig  = sig;
        e.mask = mask;
        e.exp  = val & mask;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic sb_check();
        logic [7:0] obs;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == edge_cnt) begin
                obs = sig_val(sb[i].sig) & sb[i].mask;
                checks++;
                assert (obs === sb[i].exp) else begin
                    errors++;
                    $error("FAIL %s: observed %h expected %h at edge %0d",
                           sb[i].tag, obs, sb[i].exp, edge_cnt);
                end
                sb.delete(i);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            sb_check();
        end
    endtask

    initial begin
        rst = 1'b1;
        dir = $urandom; dout = $urandom; pull_en = $urandom; db_thresh = $urandom;
        rise_en = $urandom; fall_en = $urandom; irq_clr = $urandom; pad_c = $urandom;
        step(1);
        dir = $urandom; dout = $urandom; pull_en = $urandom; pad_c = $urandom;
        rise_en = $urandom; fall_en = $urandom;
        sb_push(0, SIG_OEN,  8'hFF, 8'hFF, "rst_oen");
        sb_push(0, SIG_REN,  8'hFF, 8'hFF, "rst_ren");
        sb_push(0, SIG_PADI, 8'hFF, 8'h00, "rst_padi");
        sb_push(0, SIG_DIN,  8'hFF, 8'h00, "rst_din");
        sb_push(0, SIG_STAT, 8'hFF, 8'h00, "rst_stat");
        sb_push(0, SIG_IRQ,  8'h01, 8'h00, "rst_irq");
        step(1);
        rst = 1'b0; dir = 8'h00; dout = 8'h00; pull_en = 8'h00; db_thresh = 8'd3;
        rise_en = 8'h00; fall_en = 8'h00; irq_clr = 8'h00; pad_c = 8'h00;
        step(6);

        // Output drive, two patterns
        dir = 8'h0F; dout = 8'hA5; pull_en = 8'hF0;
        sb_push(0, SIG_OEN,  8'hFF, 8'hF0, "drv_oen");
        sb_push(0, SIG_PADI, 8'hFF, 8'hA5, "drv_padi");
        sb_push(0, SIG_REN,  8'hFF, 8'h0F, "drv_ren");
        step(1);
        dir = 8'hF0; dout = 8'h3C; pull_en = 8'h0F;
        sb_push(0, SIG_OEN,  8'hFF, 8'h0F, "drv2_oen");
        sb_push(0, SIG_PADI, 8'hFF, 8'h3C, "drv2_padi");
        sb_push(0, SIG_REN,  8'hFF, 8'hF0, "drv2_ren");
        step(1);
        dir = 8'h00; dout = 8'h00; pull_en = 8'h00; rise_en = 8'h03;
        step(2);

        // Input latency and rise status on ch0, then clear
        pad_c[0] = 1'b1;
        sb_push(LAT - 1, SIG_DIN,  8'h01, 8'h00, "ch0_din_early");
        sb_push(LAT,     SIG_DIN,  8'h01, 8'h01, "ch0_din");
        sb_push(LAT,     SIG_STAT, 8'h01, 8'h00, "ch0_stat_early");
        sb_push(LAT + 1, SIG_STAT, 8'h01, 8'h01, "ch0_stat");
        sb_push(LAT + 1, SIG_IRQ,  8'h01, 8'h01, "ch0_irq");
        step(LAT + 3);
        irq_clr = 8'h01;
        sb_push(0, SIG_STAT, 8'h01, 8'h00, "ch0_clr");
        sb_push(0, SIG_IRQ,  8'h01, 8'h00, "ch0_clr_irq");
        step(1);
        irq_clr = 8'h00;
        step(1);

        // Three-cycle pulse on ch1
        pad_c[1] = 1'b1;
`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
        for (int k = 0; k < 9; k++) begin
            sb_push(k, SIG_DIN,  8'h02, 8'h00, "glitch_din");
            sb_push(k, SIG_STAT, 8'h02, 8'h00, "glitch_stat");
        end
        step(3);
        pad_c[1] = 1'b0;
        step(7);
`else
        sb_push(1, SIG_DIN,  8'h02, 8'h02, "pulse_din_hi");
        sb_push(3, SIG_DIN,  8'h02, 8'h02, "pulse_din_hold");
        sb_push(4, SIG_DIN,  8'h02, 8'h00, "pulse_din_lo");
        sb_push(2, SIG_STAT, 8'h02, 8'h02, "pulse_stat");
        step(3);
        pad_c[1] = 1'b0;
        step(3);
        irq_clr = 8'h02;
        sb_push(0, SIG_STAT, 8'h02, 8'h00, "pulse_clr");
        sb_push(0, SIG_IRQ,  8'h01, 8'h00, "pulse_clr_irq");
        step(1);
        irq_clr = 8'h00;
        step(2);
`endif

        // Edge masking on ch3: only falls are enabled
        fall_en = 8'h08;
        pad_c[3] = 1'b1;
        sb_push(LAT + 2, SIG_STAT, 8'h08, 8'h00, "ch3_rise_masked");
        step(LAT + 3);
        pad_c[3] = 1'b0;
        sb_push(LAT,     SIG_STAT, 8'h08, 8'h00, "ch3_fall_early");
        sb_push(LAT + 1, SIG_STAT, 8'h08, 8'h08, "ch3_fall");
        sb_push(LAT + 1, SIG_IRQ,  8'h01, 8'h01, "ch3_irq");
        step(LAT + 2);
        pad_c[3] = 1'b1;
        sb_push(LAT + 2, SIG_STAT, 8'h08, 8'h08, "ch3_sticky");
        step(LAT + 3);
        irq_clr = 8'h08;
        sb_push(0, SIG_STAT, 8'hFF, 8'h00, "ch3_clr");
        sb_push(0, SIG_IRQ,  8'h01, 8'h00, "ch3_clr_irq");
        step(1);
        irq_clr = 8'h00;
        step(1);

        // Clear pulse coincident with a new enabled fall event
        pad_c[3] = 1'b0;
        sb_push(LAT + 1, SIG_STAT, 8'h08, 8'h08, "set_wins");
        sb_push(LAT + 2, SIG_STAT, 8'h08, 8'h08, "set_wins_hold");
        sb_push(LAT + 2, SIG_IRQ,  8'h01, 8'h01, "set_wins_irq");
        step(LAT + 1);
        irq_clr = 8'h08;
        step(1);
        irq_clr = 8'h00;
        step(1);

        // Threshold lowered 10 -> 2 while ch4 counter sits at 5
`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
        db_thresh = 8'd10;
        pad_c[4] = 1'b1;
        sb_push(6, SIG_DIN, 8'h10, 8'h00, "thr_before");
        sb_push(7, SIG_DIN, 8'h10, 8'h10, "thr_lowered");
        step(7);
        db_thresh = 8'd2;
        step(1);
        db_thresh = 8'd3;
        step(1);
`else
        db_thresh = 8'd10;
        pad_c[4] = 1'b1;
        sb_push(0, SIG_DIN, 8'h10, 8'h00, "thr_ignored_early");
        sb_push(1, SIG_DIN, 8'h10, 8'h10, "thr_ignored");
        step(3);
        db_thresh = 8'd3;
        step(1);
`endif
        pad_c[4] = 1'b0;
        sb_push(LAT, SIG_DIN, 8'h10, 8'h00, "ch4_fall");
        step(LAT + 2);

        // Reset in mid-operation with a ch5 count in flight
        dir = 8'hFF; dout = 8'hFF; pull_en = 8'hFF;
        step(2);
        pad_c[5] = 1'b1;
        step(3);
        rst = 1'b1;
        sb_push(0, SIG_OEN,  8'hFF, 8'hFF, "mid_rst_oen");
        sb_push(0, SIG_PADI, 8'hFF, 8'h00, "mid_rst_padi");
        sb_push(0, SIG_REN,  8'hFF, 8'hFF, "mid_rst_ren");
        sb_push(0, SIG_DIN,  8'hFF, 8'h00, "mid_rst_din");
        sb_push(0, SIG_STAT, 8'hFF, 8'h00, "mid_rst_stat");
        sb_push(0, SIG_IRQ,  8'h01, 8'h00, "mid_rst_irq");
        step(1);
        rst = 1'b0;
        sb_push(0,       SIG_OEN,  8'hFF, 8'h00, "post_rst_oen");
        sb_push(0,       SIG_PADI, 8'hFF, 8'hFF, "post_rst_padi");
        sb_push(LAT - 1, SIG_DIN,  8'h21, 8'h00, "post_rst_din_early");
        sb_push(LAT,     SIG_DIN,  8'h21, 8'h21, "post_rst_din");
        sb_push(LAT + 1, SIG_STAT, 8'hFF, 8'h01, "post_rst_stat");
        step(LAT + 4);

        checks++;
        assert (sb.size() === 0) else begin
            errors++;
            $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
